// File: rtl/bp_be_issue_queue_ctrl.sv
// bp_be_issue_queue_ctrl
//   Sequencer for the BE issue queue controls (en/clr/roll/read/cmt plus
//   cnt/size sideband). Counts issued-but-uncommitted instructions, throttles
//   issue at max_inflight_p, and orders flush (clr_i) over rollback (poison_i)
//   over normal read/commit traffic.
//   fetch_sel_p mirrors the processor config field that sizes the sideband.
//   Optional feature macro: BP_BE_ISSUE_CTRL_STATS_EN adds read/roll cycle
//   counters on issue_stat_o/roll_stat_o. Without it those ports read 0.
module bp_be_issue_queue_ctrl #(
  parameter int fetch_sel_p    = 2,
  parameter int max_inflight_p = 8,
  parameter int roll_stall_p   = 2,
  localparam int op_ptr_width_lp   = $clog2((2 ** fetch_sel_p) + 1),
  localparam int inflight_width_lp = $clog2(max_inflight_p + 1)
) (
  input  logic                         clk_i,
  input  logic                         reset_i,
  input  logic                         clr_i,
  input  logic                         poison_i,
  input  logic                         suppress_i,
  input  logic                         issue_v_i,
  input  logic                         dispatch_yumi_i,
  input  logic [op_ptr_width_lp-1:0]   issue_cnt_i,
  input  logic [op_ptr_width_lp-1:0]   issue_size_i,
  input  logic                         commit_v_i,
  input  logic [op_ptr_width_lp-1:0]   commit_cnt_i,
  input  logic [op_ptr_width_lp-1:0]   commit_size_i,
  output logic                         en_o,
  output logic                         clr_o,
  output logic                         roll_o,
  output logic                         read_o,
  output logic                         cmt_o,
  output logic [op_ptr_width_lp-1:0]   read_cnt_o,
  output logic [op_ptr_width_lp-1:0]   read_size_o,
  output logic [op_ptr_width_lp-1:0]   cmt_cnt_o,
  output logic [op_ptr_width_lp-1:0]   cmt_size_o,
  output logic [inflight_width_lp-1:0] inflight_o,
  output logic                         busy_o,
  output logic [31:0]                  issue_stat_o,
  output logic [31:0]                  roll_stat_o
);

  localparam int stall_width_lp = $clog2(roll_stall_p + 1);
  localparam logic [inflight_width_lp-1:0] max_inflight_lp = inflight_width_lp'(max_inflight_p);
  localparam logic [stall_width_lp-1:0]    stall_init_lp   = stall_width_lp'(roll_stall_p - 1);

  typedef enum logic [1:0] {e_reset, e_run, e_clear, e_roll} state_e;

  state_e                        state_r, state_n;
  logic [inflight_width_lp-1:0]  inflight_r, inflight_n;
  logic [stall_width_lp-1:0]     stall_r, stall_n;

  // State, in-flight count and rollback stall counter registers.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_r    <= e_reset;
      inflight_r <= '0;
      stall_r    <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples the pre-edge values regardless of statement order.
      state_r    <= state_n;
      inflight_r <= inflight_n;
      stall_r    <= stall_n;
    end
  end

  // Next state and all queue controls; flush beats rollback beats read/commit.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path
    // through the case/if structure can leave a latch behind.
    state_n    = state_r;
    inflight_n = inflight_r;
    stall_n    = stall_r;
    en_o       = 1'b0;
    clr_o      = 1'b0;
    roll_o     = 1'b0;
    read_o     = 1'b0;
    cmt_o      = 1'b0;

    unique case (state_r)
      e_reset: begin
        clr_o   = 1'b1;
        state_n = e_run;
      end
      e_run: begin
        en_o   = ~suppress_i & (inflight_r < max_inflight_lp);
        read_o = dispatch_yumi_i & issue_v_i & en_o;
        cmt_o  = commit_v_i;
        if (read_o && !cmt_o)
          inflight_n = inflight_r + 1'b1;
        else if (!read_o && cmt_o && (inflight_r != '0))
          inflight_n = inflight_r - 1'b1;
      end
      e_roll: begin
        cmt_o = commit_v_i;
        if (cmt_o && (inflight_r != '0))
          inflight_n = inflight_r - 1'b1;
        if (stall_r == '0)
          state_n = e_run;
        else
          stall_n = stall_r - 1'b1;
      end
      e_clear: begin
        state_n = e_run;
      end
      default: state_n = e_reset;
    endcase

    if (state_r != e_reset) begin
      if (clr_i) begin
        en_o       = 1'b0;
        clr_o      = 1'b1;
        roll_o     = 1'b0;
        read_o     = 1'b0;
        cmt_o      = 1'b0;
        inflight_n = '0;
        stall_n    = '0;
        state_n    = e_clear;
      end else if (poison_i && (state_r == e_run || state_r == e_roll)) begin
        en_o       = 1'b0;
        roll_o     = 1'b1;
        read_o     = 1'b0;
        cmt_o      = commit_v_i;
        inflight_n = '0;
        stall_n    = stall_init_lp;
        state_n    = e_roll;
      end
    end
  end

  // Sideband is a straight pass-through, held at zero while coming out of reset.
  assign read_cnt_o  = (state_r == e_reset) ? '0 : issue_cnt_i;
  assign read_size_o = (state_r == e_reset) ? '0 : issue_size_i;
  assign cmt_cnt_o   = (state_r == e_reset) ? '0 : commit_cnt_i;
  assign cmt_size_o  = (state_r == e_reset) ? '0 : commit_size_i;

  assign inflight_o = inflight_r;
  assign busy_o     = (state_r != e_run);

  // A commit with nothing in flight during normal running means upstream broke protocol.
  a_no_underflow: assert property (@(posedge clk_i) disable iff (reset_i)
    (state_r == e_run && cmt_o && !read_o) |-> (inflight_r != '0));

`ifdef BP_BE_ISSUE_CTRL_STATS_EN
  logic [31:0] issue_stat_r, roll_stat_r;

  // Free-running read/roll cycle counters; only reset clears them, they wrap.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      issue_stat_r <= '0;
      roll_stat_r  <= '0;
    end else begin
      if (read_o) issue_stat_r <= issue_stat_r + 32'd1;
      if (roll_o) roll_stat_r  <= roll_stat_r + 32'd1;
    end
  end

  assign issue_stat_o = issue_stat_r;
  assign roll_stat_o  = roll_stat_r;
`else
  assign issue_stat_o = '0;
  assign roll_stat_o  = '0;
`endif

endmodule

// File: tb/tb_bp_be_issue_queue_ctrl.sv
// Directed bench for bp_be_issue_queue_ctrl (default parameters:
// fetch_sel_p=2 -> 3-bit sideband, max_inflight_p=8, roll_stall_p=2).
// Inputs change 1 time unit after the rising edge; outputs are compared
// 1 unit later, well before the next rising edge.
module tb_bp_be_issue_queue_ctrl;

  logic       clk_i = 1'b0;
  logic       reset_i, clr_i, poison_i, suppress_i, issue_v_i, dispatch_yumi_i, commit_v_i;
  logic [2:0] issue_cnt_i, issue_size_i, commit_cnt_i, commit_size_i;
  logic       en_o, clr_o, roll_o, read_o, cmt_o, busy_o;
  logic [2:0] read_cnt_o, read_size_o, cmt_cnt_o, cmt_size_o;
  logic [3:0] inflight_o;
  logic [31:0] issue_stat_o, roll_stat_o;

  int errors = 0;
  int checks = 0;

  always #5 clk_i = ~clk_i;

  bp_be_issue_queue_ctrl dut (
    .clk_i(clk_i), .reset_i(reset_i), .clr_i(clr_i), .poison_i(poison_i),
    .suppress_i(suppress_i), .issue_v_i(issue_v_i), .dispatch_yumi_i(dispatch_yumi_i),
    .issue_cnt_i(issue_cnt_i), .issue_size_i(issue_size_i), .commit_v_i(commit_v_i),
    .commit_cnt_i(commit_cnt_i), .commit_size_i(commit_size_i),
    .en_o(en_o), .clr_o(clr_o), .roll_o(roll_o), .read_o(read_o), .cmt_o(cmt_o),
    .read_cnt_o(read_cnt_o), .read_size_o(read_size_o), .cmt_cnt_o(cmt_cnt_o),
    .cmt_size_o(cmt_size_o), .inflight_o(inflight_o), .busy_o(busy_o),
    .issue_stat_o(issue_stat_o), .roll_stat_o(roll_stat_o)
  );

  task automatic idle();
    clr_i = 0; poison_i = 0; suppress_i = 0; issue_v_i = 0; dispatch_yumi_i = 0;
    commit_v_i = 0; issue_cnt_i = 0; issue_size_i = 0; commit_cnt_i = 0; commit_size_i = 0;
  endtask

  task automatic tick();
    @(posedge clk_i); #1;
  endtask

  task automatic test_reset();
    idle(); reset_i = 1;
    repeat (3) tick();
    reset_i = 0; #1;
    checks++; if (clr_o !== 1'b1) begin errors++; $display("FAIL reset_clr_o got=%b exp=1", clr_o); end
    checks++; if (en_o !== 1'b0) begin errors++; $display("FAIL reset_en_o got=%b exp=0", en_o); end
    checks++; if (busy_o !== 1'b1) begin errors++; $display("FAIL reset_busy_o got=%b exp=1", busy_o); end
    tick(); #1;
    checks++; if (clr_o !== 1'b0) begin errors++; $display("FAIL run_clr_o got=%b exp=0", clr_o); end
    checks++; if (en_o !== 1'b1) begin errors++; $display("FAIL run_en_o got=%b exp=1", en_o); end
    checks++; if (inflight_o !== 4'd0) begin errors++; $display("FAIL run_inflight got=%0d exp=0", inflight_o); end
    checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL run_busy_o got=%b exp=0", busy_o); end
  endtask

  task automatic test_fill_limit();
    for (int i = 0; i < 8; i++) begin
      issue_v_i = 1; dispatch_yumi_i = 1; #1;
      checks++; if (read_o !== 1'b1) begin errors++; $display("FAIL fill_read_%0d got=%b exp=1", i, read_o); end
      tick();
    end
    #1;
    checks++; if (inflight_o !== 4'd8) begin errors++; $display("FAIL fill_inflight got=%0d exp=8", inflight_o); end
    checks++; if (en_o !== 1'b0) begin errors++; $display("FAIL fill_en_at_limit got=%b exp=0", en_o); end
    checks++; if (read_o !== 1'b0) begin errors++; $display("FAIL fill_read_at_limit got=%b exp=0", read_o); end
    issue_v_i = 0; dispatch_yumi_i = 0; commit_v_i = 1; #1;
    checks++; if (cmt_o !== 1'b1) begin errors++; $display("FAIL fill_cmt_o got=%b exp=1", cmt_o); end
    tick(); commit_v_i = 0; #1;
    checks++; if (inflight_o !== 4'd7) begin errors++; $display("FAIL fill_after_commit got=%0d exp=7", inflight_o); end
    checks++; if (en_o !== 1'b1) begin errors++; $display("FAIL fill_en_below_limit got=%b exp=1", en_o); end
    suppress_i = 1; issue_v_i = 1; dispatch_yumi_i = 1; #1;
    checks++; if (en_o !== 1'b0 || read_o !== 1'b0) begin errors++; $display("FAIL suppress en/read got=%b/%b exp=0/0", en_o, read_o); end
    tick(); idle(); #1;
    checks++; if (inflight_o !== 4'd7) begin errors++; $display("FAIL suppress_inflight got=%0d exp=7", inflight_o); end
  endtask

  task automatic test_read_commit_same_cycle();
    commit_v_i = 1;
    repeat (3) tick();
    commit_v_i = 0; #1;
    checks++; if (inflight_o !== 4'd4) begin errors++; $display("FAIL rc_pre_inflight got=%0d exp=4", inflight_o); end
    issue_v_i = 1; dispatch_yumi_i = 1; commit_v_i = 1;
    issue_cnt_i = 3'd5; issue_size_i = 3'd2; commit_cnt_i = 3'd1; commit_size_i = 3'd6; #1;
    checks++; if (read_o !== 1'b1 || cmt_o !== 1'b1) begin errors++; $display("FAIL rc_read_cmt got=%b%b exp=11", read_o, cmt_o); end
    checks++; if (read_cnt_o !== 3'd5) begin errors++; $display("FAIL rc_read_cnt got=%0d exp=5", read_cnt_o); end
    checks++; if (read_size_o !== 3'd2) begin errors++; $display("FAIL rc_read_size got=%0d exp=2", read_size_o); end
    checks++; if (cmt_cnt_o !== 3'd1) begin errors++; $display("FAIL rc_cmt_cnt got=%0d exp=1", cmt_cnt_o); end
    checks++; if (cmt_size_o !== 3'd6) begin errors++; $display("FAIL rc_cmt_size got=%0d exp=6", cmt_size_o); end
    tick(); idle(); #1;
    checks++; if (inflight_o !== 4'd4) begin errors++; $display("FAIL rc_inflight got=%0d exp=4", inflight_o); end
  endtask

  task automatic test_poison();
    commit_v_i = 1; tick(); commit_v_i = 0; #1;
    checks++; if (inflight_o !== 4'd3) begin errors++; $display("FAIL poison_pre_inflight got=%0d exp=3", inflight_o); end
    poison_i = 1; commit_v_i = 1; issue_v_i = 1; dispatch_yumi_i = 1; #1;
    checks++; if (roll_o !== 1'b1) begin errors++; $display("FAIL poison_roll_o got=%b exp=1", roll_o); end
    checks++; if (cmt_o !== 1'b1) begin errors++; $display("FAIL poison_cmt_o got=%b exp=1", cmt_o); end
    checks++; if (read_o !== 1'b0) begin errors++; $display("FAIL poison_read_o got=%b exp=0", read_o); end
    tick(); poison_i = 0; #1;
    // first stall cycle: commit at zero in-flight must floor, not wrap
    checks++; if (en_o !== 1'b0 || read_o !== 1'b0) begin errors++; $display("FAIL roll1 en/read got=%b/%b exp=0/0", en_o, read_o); end
    checks++; if (cmt_o !== 1'b1) begin errors++; $display("FAIL roll1_cmt_o got=%b exp=1", cmt_o); end
    checks++; if (inflight_o !== 4'd0) begin errors++; $display("FAIL roll1_inflight got=%0d exp=0", inflight_o); end
    tick(); idle(); #1;
    checks++; if (en_o !== 1'b0 || busy_o !== 1'b1) begin errors++; $display("FAIL roll2 en/busy got=%b/%b exp=0/1", en_o, busy_o); end
    checks++; if (inflight_o !== 4'd0) begin errors++; $display("FAIL roll2_inflight got=%0d exp=0", inflight_o); end
    tick(); #1;
    checks++; if (en_o !== 1'b1 || busy_o !== 1'b0) begin errors++; $display("FAIL roll_exit en/busy got=%b/%b exp=1/0", en_o, busy_o); end
  endtask

  task automatic test_clear();
    clr_i = 1; poison_i = 1; commit_v_i = 1; issue_v_i = 1; dispatch_yumi_i = 1; #1;
    checks++; if (clr_o !== 1'b1 || roll_o !== 1'b0) begin errors++; $display("FAIL clr_prio clr/roll got=%b/%b exp=1/0", clr_o, roll_o); end
    checks++; if (read_o !== 1'b0 || cmt_o !== 1'b0) begin errors++; $display("FAIL clr_read_cmt got=%b/%b exp=0/0", read_o, cmt_o); end
    tick(); idle(); #1;
    checks++; if (en_o !== 1'b0 || clr_o !== 1'b0 || busy_o !== 1'b1) begin errors++; $display("FAIL clear_state en/clr/busy got=%b/%b/%b exp=0/0/1", en_o, clr_o, busy_o); end
    tick(); #1;
    checks++; if (en_o !== 1'b1 || busy_o !== 1'b0) begin errors++; $display("FAIL clear_exit en/busy got=%b/%b exp=1/0", en_o, busy_o); end
    // clr_i during a rollback stall still wins
    poison_i = 1; tick(); poison_i = 0; clr_i = 1; #1;
    checks++; if (clr_o !== 1'b1 || roll_o !== 1'b0) begin errors++; $display("FAIL clr_in_roll clr/roll got=%b/%b exp=1/0", clr_o, roll_o); end
    tick(); idle(); tick(); #1;
    checks++; if (en_o !== 1'b1 || inflight_o !== 4'd0) begin errors++; $display("FAIL clr_in_roll_exit en/infl got=%b/%0d exp=1/0", en_o, inflight_o); end
  endtask

  task automatic test_stats();
    logic [31:0] exp_issue, exp_roll;
`ifdef BP_BE_ISSUE_CTRL_STATS_EN
    exp_issue = 32'd5; exp_roll = 32'd2;
`else
    exp_issue = 32'd0; exp_roll = 32'd0;
`endif
    idle(); reset_i = 1; repeat (2) tick(); reset_i = 0; tick();
    issue_v_i = 1; dispatch_yumi_i = 1; repeat (5) tick(); idle();
    for (int r = 0; r < 2; r++) begin
      poison_i = 1; tick(); poison_i = 0; repeat (2) tick();
    end
    clr_i = 1; tick(); clr_i = 0; repeat (2) tick(); #1;
    checks++; if (issue_stat_o !== exp_issue) begin errors++; $display("FAIL stats_issue got=%0d exp=%0d", issue_stat_o, exp_issue); end
    checks++; if (roll_stat_o !== exp_roll) begin errors++; $display("FAIL stats_roll got=%0d exp=%0d", roll_stat_o, exp_roll); end
    reset_i = 1; tick(); #1;
    checks++; if (issue_stat_o !== 32'd0 || roll_stat_o !== 32'd0) begin errors++; $display("FAIL stats_reset got=%0d/%0d exp=0/0", issue_stat_o, roll_stat_o); end
    reset_i = 0; tick();
  endtask

  initial begin
    test_reset();
    test_fill_limit();
    test_read_commit_same_cycle();
    test_poison();
    test_clear();
    test_stats();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
